// File: rtl/permute_sched.sv
// permute_sched: sequencing controller for the NTT lane scatter network.
// Walks (stage, group) counters, emits a rotating destination select per
// lane, gates beats through the external network with valid/ready and
// registers the permuted result.

// Per-lane destination select: dest = (LANE + offset) mod N.
// The sum is at most 2N-2, so one conditional subtract replaces a divider.
module permute_lane_sel #(
  parameter int N    = 4,
  parameter int SELW = 3,
  parameter int LANE = 0
)(
  input  logic [SELW-1:0] offset,
  output logic [SELW-1:0] dest
);
  localparam logic [SELW:0] N_EXT = (SELW+1)'(N);
  logic [SELW:0] sum;

  assign sum  = (SELW+1)'(LANE) + {1'b0, offset};
  assign dest = (sum >= N_EXT) ? SELW'(sum - N_EXT) : sum[SELW-1:0];
endmodule

module permute_sched #(
  parameter int P     = 2,
  parameter int N     = 2*P,
  parameter int W     = 32,
  // one spare bit beyond log2(N) so an out-of-range rotation step is
  // representable and can be flagged
  parameter int MAP   = $clog2(N) + 1,
  parameter int SELW  = MAP,
  parameter int GRP_W = 8,
  parameter int STG_W = 4
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [GRP_W-1:0]  cfg_groups,
  input  logic [STG_W-1:0]  cfg_stages,
  input  logic [SELW-1:0]   cfg_rot_step,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*W-1:0]    in_data,
  output logic [N*W-1:0]    net_in_bus,
  output logic [N*SELW-1:0] net_dest_bus,
  input  logic [N*W-1:0]    net_out_bus,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*W-1:0]    out_data,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [SELW:0] N_EXT = (SELW+1)'(N);

  state_t           state;
  logic [GRP_W-1:0] groups_q, g;
  logic [STG_W-1:0] stages_q, s;
  logic [SELW-1:0]  rot_q, base, offset;

  logic             accept, last_g, last_beat, rot_bad;
  logic [SELW:0]    base_sum, off_sum;
  logic [SELW-1:0]  base_nxt, off_nxt;

  assign in_ready   = (state == RUN) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign last_g     = (g == groups_q - GRP_W'(1));
  assign last_beat  = last_g && (s == stages_q - STG_W'(1));
  assign busy       = (state != IDLE);
  assign net_in_bus = in_data;
  assign rot_bad    = ({1'b0, cfg_rot_step} >= N_EXT);

  // next stage base and next in-stage offset, both reduced mod N
  assign base_sum = {1'b0, base} + {1'b0, rot_q};
  assign base_nxt = (base_sum >= N_EXT) ? SELW'(base_sum - N_EXT) : base_sum[SELW-1:0];
  assign off_sum  = {1'b0, offset} + (SELW+1)'(1);
  assign off_nxt  = (off_sum >= N_EXT) ? SELW'(off_sum - N_EXT) : off_sum[SELW-1:0];

  // one select unit per lane; offset is 0 outside a run so IDLE is identity
  for (genvar j = 0; j < N; j++) begin : g_lane
    permute_lane_sel #(.N(N), .SELW(SELW), .LANE(j)) u_sel (
      .offset (offset),
      .dest   (net_dest_bus[j*SELW +: SELW])
    );
  end

  // run control: config latch, (stage, group) counters, done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      groups_q <= '0;
      stages_q <= '0;
      rot_q    <= '0;
      g        <= '0;
      s        <= '0;
      base     <= '0;
      offset   <= '0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            groups_q <= cfg_groups;
            stages_q <= cfg_stages;
            rot_q    <= rot_bad ? '0 : cfg_rot_step;
            cfg_err  <= rot_bad;
            g        <= '0;
            s        <= '0;
            base     <= '0;
            offset   <= '0;
            if (cfg_groups == '0 || cfg_stages == '0) done  <= 1'b1;
            else                                      state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (last_g) begin
              g      <= '0;
              s      <= s + STG_W'(1);
              base   <= base_nxt;
              offset <= base_nxt;
            end else begin
              g      <= g + GRP_W'(1);
              offset <= off_nxt;
            end
            if (last_beat) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!out_valid || out_ready) begin
            state  <= IDLE;
            done   <= 1'b1;
            g      <= '0;
            s      <= '0;
            base   <= '0;
            offset <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // output register: load on accept, drop valid on a bare output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= net_out_bus;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_permute_sched.sv
// Directed bench for permute_sched with N=4, W=8 and a behavioural
// scatter network: out lane dest[j] receives in lane j.
module tb_permute_sched;
  localparam int P = 2, N = 4, W = 8, SELW = 3, GRP_W = 8, STG_W = 4;

  logic              clk = 1'b0;
  logic              rst_n, start, in_valid, in_ready, out_valid, out_ready;
  logic              busy, done, cfg_err;
  logic [GRP_W-1:0]  cfg_groups;
  logic [STG_W-1:0]  cfg_stages;
  logic [SELW-1:0]   cfg_rot_step;
  logic [N*W-1:0]    in_data, net_in_bus, net_out_bus, out_data;
  logic [N*SELW-1:0] net_dest_bus;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  permute_sched #(.P(P), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_groups(cfg_groups), .cfg_stages(cfg_stages), .cfg_rot_step(cfg_rot_step),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .net_in_bus(net_in_bus), .net_dest_bus(net_dest_bus), .net_out_bus(net_out_bus),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  // scatter network model
  always_comb begin
    int d;
    net_out_bus = '0;
    for (int j = 0; j < N; j++) begin
      d = int'(net_dest_bus[j*SELW +: SELW]);
      if (d < N) net_out_bus[d*W +: W] = net_in_bus[j*W +: W];
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_groups = '0; cfg_stages = '0; cfg_rot_step = '0; in_data = '0;
    #3;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b exp 0", out_valid); end
    tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b exp 0", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL reset_cfg_err: got %0b exp 0", cfg_err); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %0b exp 0", in_ready); end
    tests++; if (net_dest_bus !== 12'o3210) begin fails++; $display("FAIL reset_dest: got %o exp 3210", net_dest_bus); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_idle: got busy=%0b done=%0b exp 0 0", busy, done); end
  endtask

  task automatic test_basic(input string tag);
    logic [31:0] din [4];
    logic [31:0] eo [4];
    logic [11:0] ed [4];
    din = '{32'h0D0C0B0A, 32'h1D1C1B1A, 32'h2D2C2B2A, 32'h3D3C3B3A};
    eo  = '{32'h0D0C0B0A, 32'h1C1B1A1D, 32'h2C2B2A2D, 32'h3B3A3D3C};
    ed  = '{12'o3210, 12'o0321, 12'o0321, 12'o1032};
    cfg_groups = 8'd2; cfg_stages = 4'd2; cfg_rot_step = 3'd1; out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    tests++; if (busy !== 1'b1 || cfg_err !== 1'b0) begin fails++; $display("FAIL %s_start: got busy=%0b err=%0b exp 1 0", tag, busy, cfg_err); end
    for (int i = 0; i < 4; i++) begin
      in_data = din[i]; in_valid = 1'b1; #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL %s_in_ready%0d: got %0b exp 1", tag, i, in_ready); end
      tests++; if (net_dest_bus !== ed[i]) begin fails++; $display("FAIL %s_dest%0d: got %o exp %o", tag, i, net_dest_bus, ed[i]); end
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b1 || out_data !== eo[i]) begin fails++; $display("FAIL %s_out%0d: got v=%0b %h exp 1 %h", tag, i, out_valid, out_data, eo[i]); end
    end
    in_valid = 1'b0;
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL %s_drain: got busy=%0b done=%0b exp 1 0", tag, busy, done); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL %s_done: got done=%0b busy=%0b ov=%0b exp 1 0 0", tag, done, busy, out_valid); end
    tests++; if (net_dest_bus !== 12'o3210) begin fails++; $display("FAIL %s_idle_dest: got %o exp 3210", tag, net_dest_bus); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL %s_done_width: got %0b exp 0", tag, done); end
  endtask

  task automatic test_wrap();
    logic [31:0] din [3];
    logic [31:0] eo [3];
    logic [11:0] ed [3];
    din = '{32'h0D0C0B0A, 32'h1D1C1B1A, 32'h2D2C2B2A};
    eo  = '{32'h0D0C0B0A, 32'h1A1D1C1B, 32'h2B2A2D2C};
    ed  = '{12'o3210, 12'o2103, 12'o1032};
    cfg_groups = 8'd1; cfg_stages = 4'd3; cfg_rot_step = 3'd3; out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL wrap_cfg_err: got %0b exp 0", cfg_err); end
    for (int i = 0; i < 3; i++) begin
      in_data = din[i]; in_valid = 1'b1; #1;
      tests++; if (net_dest_bus !== ed[i]) begin fails++; $display("FAIL wrap_dest%0d: got %o exp %o", i, net_dest_bus, ed[i]); end
      @(posedge clk); #1;
      tests++; if (out_data !== eo[i]) begin fails++; $display("FAIL wrap_out%0d: got %h exp %h", i, out_data, eo[i]); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL wrap_done: got done=%0b busy=%0b exp 1 0", done, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] din [4];
    logic [31:0] eo [4];
    logic [11:0] ed [4];
    din = '{32'h4D4C4B4A, 32'h5D5C5B5A, 32'h6D6C6B6A, 32'h7D7C7B7A};
    eo  = '{32'h4D4C4B4A, 32'h5C5B5A5D, 32'h6C6B6A6D, 32'h7B7A7D7C};
    ed  = '{12'o3210, 12'o0321, 12'o0321, 12'o1032};
    cfg_groups = 8'd2; cfg_stages = 4'd2; cfg_rot_step = 3'd1; out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    in_data = din[0]; in_valid = 1'b1;
    @(posedge clk); #1;
    tests++; if (out_data !== eo[0]) begin fails++; $display("FAIL bp_out0: got %h exp %h", out_data, eo[0]); end
    out_ready = 1'b0; in_data = din[1];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall_ready%0d: got %0b exp 0", k, in_ready); end
      tests++; if (out_valid !== 1'b1 || out_data !== eo[0]) begin fails++; $display("FAIL bp_stall_hold%0d: got v=%0b %h exp 1 %h", k, out_valid, out_data, eo[0]); end
      tests++; if (net_dest_bus !== ed[1]) begin fails++; $display("FAIL bp_stall_dest%0d: got %o exp %o", k, net_dest_bus, ed[1]); end
    end
    out_ready = 1'b1; #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %0b exp 1", in_ready); end
    for (int i = 1; i < 4; i++) begin
      in_data = din[i]; in_valid = 1'b1; #1;
      tests++; if (net_dest_bus !== ed[i]) begin fails++; $display("FAIL bp_dest%0d: got %o exp %o", i, net_dest_bus, ed[i]); end
      @(posedge clk); #1;
      tests++; if (out_data !== eo[i]) begin fails++; $display("FAIL bp_out%0d: got %h exp %h", i, out_data, eo[i]); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL bp_done: got done=%0b busy=%0b exp 1 0", done, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_busy();
    cfg_groups = 8'd0; cfg_stages = 4'd2; cfg_rot_step = 3'd1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h0D0C0B0A; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    tests++; if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL zero_done: got done=%0b busy=%0b rdy=%0b exp 1 0 0", done, busy, in_ready); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL zero_after: got done=%0b busy=%0b rdy=%0b exp 0 0 0", done, busy, in_ready); end
    in_valid = 1'b0;
    cfg_groups = 8'd1; cfg_stages = 4'd2; cfg_rot_step = 3'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    in_data = 32'h0D0C0B0A; in_valid = 1'b1;
    @(posedge clk); #1;
    tests++; if (out_data !== 32'h0D0C0B0A) begin fails++; $display("FAIL busy_out0: got %h exp 0d0c0b0a", out_data); end
    in_valid = 1'b0;
    cfg_groups = 8'd1; cfg_stages = 4'd1; cfg_rot_step = 3'd6; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    tests++; if (busy !== 1'b1 || cfg_err !== 1'b0) begin fails++; $display("FAIL busy_start_ignored: got busy=%0b err=%0b exp 1 0", busy, cfg_err); end
    tests++; if (net_dest_bus !== 12'o0321) begin fails++; $display("FAIL busy_dest: got %o exp 0321", net_dest_bus); end
    in_data = 32'h1D1C1B1A; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    tests++; if (out_data !== 32'h1C1B1A1D || busy !== 1'b1) begin fails++; $display("FAIL busy_out1: got %h busy=%0b exp 1c1b1a1d 1", out_data, busy); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL busy_done: got %0b exp 1", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_rot();
    logic [31:0] din [2];
    din = '{32'h8D8C8B8A, 32'h9D9C9B9A};
    cfg_groups = 8'd1; cfg_stages = 4'd2; cfg_rot_step = 3'd5; out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL illegal_cfg_err: got %0b exp 1", cfg_err); end
    for (int i = 0; i < 2; i++) begin
      in_data = din[i]; in_valid = 1'b1; #1;
      tests++; if (net_dest_bus !== 12'o3210) begin fails++; $display("FAIL illegal_dest%0d: got %o exp 3210", i, net_dest_bus); end
      @(posedge clk); #1;
      tests++; if (out_data !== din[i]) begin fails++; $display("FAIL illegal_out%0d: got %h exp %h", i, out_data, din[i]); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (done !== 1'b1 || cfg_err !== 1'b1) begin fails++; $display("FAIL illegal_done: got done=%0b err=%0b exp 1 1", done, cfg_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    cfg_groups = 8'd2; cfg_stages = 4'd2; cfg_rot_step = 3'd1; out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    in_data = 32'h0D0C0B0A; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 32'h1D1C1B1A;
    @(posedge clk); #1; in_valid = 1'b0;
    tests++; if (out_data !== 32'h1C1B1A1D) begin fails++; $display("FAIL rmid_out1: got %h exp 1c1b1a1d", out_data); end
    #2 rst_n = 1'b0; #1;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rmid_clear: got ov=%0b busy=%0b done=%0b exp 0 0 0", out_valid, busy, done); end
    tests++; if (out_data !== '0 || in_ready !== 1'b0) begin fails++; $display("FAIL rmid_data: got %h rdy=%0b exp 0 0", out_data, in_ready); end
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rmid_no_done: got done=%0b busy=%0b exp 0 0", done, busy); end
    test_basic("rerun");
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_wrap();
    test_backpressure();
    test_zero_busy();
    test_illegal_rot();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
